// File: rtl/alarme_controle.sv
// Night-time door alarm: exit delay, armed watch, entry delay, latched siren.
// Every output is a register; inputs sampled at one edge show up after that edge.
module alarme_controle #(
  parameter int DELAY_SAIDA   = 5,
  parameter int DELAY_ENTRADA = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       porta,
  input  logic       relogio,
  input  logic       interruptor,
  output logic       alarme,
  output logic       pisca,
  output logic [2:0] estado,
  output logic [3:0] contador,
  output logic [7:0] SEG
);

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARADO = 3'd4
  } estado_t;

  // Load values are clamped to one decimal digit so the counter never exceeds 9.
  localparam logic [3:0] LOAD_SAIDA   = (DELAY_SAIDA > 9)   ? 4'd9 :
                                        (DELAY_SAIDA < 1)   ? 4'd1 : 4'(DELAY_SAIDA);
  localparam logic [3:0] LOAD_ENTRADA = (DELAY_ENTRADA > 9) ? 4'd9 :
                                        (DELAY_ENTRADA < 1) ? 4'd1 : 4'(DELAY_ENTRADA);

  estado_t     r_estado;
  logic [3:0]  r_contador;
  logic        r_alarme;
  logic        r_pisca;
  logic [7:0]  r_seg;

  estado_t     w_estado_nxt;
  logic [3:0]  w_contador_nxt;
  logic        w_alarme_nxt;
  logic        w_pisca_nxt;
  logic [7:0]  w_seg_nxt;
  logic        w_blink;

  function automatic logic [7:0] digito_7seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_estado   <= DESARMADO;
      r_contador <= 4'd0;
      r_alarme   <= 1'b0;
      r_pisca    <= 1'b0;
      r_seg      <= 8'h00;
    end else begin
      r_estado   <= w_estado_nxt;
      r_contador <= w_contador_nxt;
      r_alarme   <= w_alarme_nxt;
      r_pisca    <= w_pisca_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  // Next state; the owner key beats everything once the system is not idle.
  always_comb begin
    w_estado_nxt   = DESARMADO;
    w_contador_nxt = 4'd0;
    if ((r_estado != DESARMADO) && interruptor) begin
      w_estado_nxt   = DESARMADO;
      w_contador_nxt = 4'd0;
    end else begin
      case (r_estado)
        DESARMADO: begin
          if (relogio && !interruptor) begin
            w_estado_nxt   = SAIDA;
            w_contador_nxt = LOAD_SAIDA;
          end
        end
        SAIDA: begin
          if (!relogio) begin
            w_estado_nxt = DESARMADO;
          end else if (r_contador == 4'd0) begin
            w_estado_nxt = ARMADO;
          end else begin
            w_estado_nxt   = SAIDA;
            w_contador_nxt = r_contador - 4'd1;
          end
        end
        ARMADO: begin
          if (!relogio) begin
            w_estado_nxt = DESARMADO;
          end else if (porta) begin
            w_estado_nxt   = ENTRADA;
            w_contador_nxt = LOAD_ENTRADA;
          end else begin
            w_estado_nxt = ARMADO;
          end
        end
        ENTRADA: begin
          if (r_contador == 4'd0) begin
            w_estado_nxt = DISPARADO;
          end else begin
            w_estado_nxt   = ENTRADA;
            w_contador_nxt = r_contador - 4'd1;
          end
        end
        DISPARADO: w_estado_nxt = DISPARADO;
        default:   w_estado_nxt = DESARMADO;
      endcase
    end
  end

  // Output registers are loaded from the next state so they line up with estado.
  always_comb begin
    w_blink      = (w_estado_nxt == SAIDA) || (w_estado_nxt == ENTRADA) ||
                   (w_estado_nxt == DISPARADO);
    w_alarme_nxt = (w_estado_nxt == DISPARADO);
    w_pisca_nxt  = w_blink ? ~r_pisca : 1'b0;
    w_seg_nxt    = 8'h00;
    case (w_estado_nxt)
      SAIDA, ENTRADA: w_seg_nxt = digito_7seg(w_contador_nxt);
      ARMADO:         w_seg_nxt = 8'h80;
      DISPARADO:      w_seg_nxt = 8'h76;
      default:        w_seg_nxt = 8'h00;
    endcase
  end

  assign estado   = r_estado;
  assign contador = r_contador;
  assign alarme   = r_alarme;
  assign pisca    = r_pisca;
  assign SEG      = r_seg;

endmodule

// File: tb/tb_alarme_controle.sv
// Directed scenarios for alarme_controle; expectations queued per cycle, checked by a monitor.
module tb_alarme_controle;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       porta = 1'b0;
  logic       relogio = 1'b0;
  logic       interruptor = 1'b0;
  logic       alarme;
  logic       pisca;
  logic [2:0] estado;
  logic [3:0] contador;
  logic [7:0] SEG;

  int n_chk  = 0;
  int n_pass = 0;
  logic m_pisca = 1'b0;
  logic [16:0] exp_q[$];

  alarme_controle #(.DELAY_SAIDA(5), .DELAY_ENTRADA(3)) dut (
    .clk_2(clk_2), .reset(reset), .porta(porta), .relogio(relogio),
    .interruptor(interruptor), .alarme(alarme), .pisca(pisca),
    .estado(estado), .contador(contador), .SEG(SEG)
  );

  always #5 clk_2 = ~clk_2;

  function automatic logic [7:0] seg_of(input logic [2:0] e, input logic [3:0] c);
    logic [7:0] t [0:9];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (e == 3'd1 || e == 3'd3) return t[c];
    if (e == 3'd2) return 8'h80;
    if (e == 3'd4) return 8'h76;
    return 8'h00;
  endfunction

  // One clock of stimulus plus the registered response expected after that edge.
  task automatic step(input logic rst, input logic p, input logic r, input logic i,
                      input logic [2:0] e, input logic [3:0] c);
    logic al;
    @(negedge clk_2);
    reset = rst; porta = p; relogio = r; interruptor = i;
    if (e == 3'd1 || e == 3'd3 || e == 3'd4) m_pisca = ~m_pisca;
    else m_pisca = 1'b0;
    al = (e == 3'd4);
    exp_q.push_back({e, c, al, m_pisca, seg_of(e, c)});
  endtask

  // Exit delay 5..0 then ARMADO; porta on the final sample must not matter.
  task automatic arm_seq(input logic porta_last);
    for (int k = 5; k >= 0; k--) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'(k));
    step(1'b0, porta_last, 1'b1, 1'b0, 3'd2, 4'd0);
  endtask

  initial begin : monitor
    logic [16:0] got, exp_v;
    forever begin
      @(posedge clk_2);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {estado, contador, alarme, pisca, SEG};
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL chk%0d: got estado=%0d contador=%0d alarme=%0b pisca=%0b SEG=%02h, required estado=%0d contador=%0d alarme=%0b pisca=%0b SEG=%02h",
                      n_chk, got[16:14], got[13:10], got[9], got[8], got[7:0],
                      exp_v[16:14], exp_v[13:10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  initial begin : stimulus
    // Reset, with arming inputs active to show reset overrides them.
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);

    // Arm, then intrusion through the entry delay into the siren.
    arm_seq(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'd0);

    // Latch: morning and door activity cannot clear the siren.
    for (int k = 0; k < 10; k++) step(1'b0, 1'(k % 2), 1'b0, 1'b0, 3'd4, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Abort in the entry delay at contador=2.
    arm_seq(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Morning while armed, and while in the exit delay at contador=3.
    arm_seq(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Reset in the exit delay at contador=4, then resume.
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd4);

    // Key held while idle blocks arming.
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);

    // Entry delay ignores morning and door.
    arm_seq(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0);

    // Reset while the siren is latched.
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_2);
    repeat (2) @(posedge clk_2);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    if (n_chk < 12) begin
      n_chk++;
      $display("FAIL count: %0d checks made, required at least 12", n_chk - 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
